xor_cipher_core: RTL and testbench



---
 rtl/xor_cipher_core.sv | 136 +++++++++++++
 tb/tb_xor_cipher_core.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_cipher_core.sv
// xor_cipher_core
// Two-stage streaming XOR/rotate cipher with a rotating key schedule.
//
// Encrypt: out = rotl(in, PROT) ^ key
// Decrypt: out = rotr(in ^ key, PROT)
// The key word comes from a bank of NKEYS words. The bank advances to the
// next word each time 'period' beats have been accepted. A period of 0
// freezes the key index.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready
// are both high. A producer holds valid and its payload stable until that
// edge. ready never depends on the same side's valid. in_ready equals the
// pipeline advance condition (!out_valid || out_ready). out_valid and
// out_data come straight from registers and stay unchanged while out_ready
// is low.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input beat handshake
//   in_data, in_mode      beat payload (mode 0 encrypt, 1 decrypt)
//   out_valid/out_ready   result handshake
//   out_data              result word
//   cfg_we                one-cycle strobe to load key bank and period
//   cfg_key, cfg_rot      new key bank (word i at [i*DW +: DW]) and period
//   cfg_err               one-cycle pulse when a cfg_we was refused
//   busy                  either pipeline stage holds a beat
module xor_cipher_core #(
  parameter int                    DW       = 8,
  parameter int                    NKEYS    = 3,
  parameter int                    PROT     = 1,
  parameter logic [NKEYS*DW-1:0]   KEY_INIT = 24'h0FA53C,
  parameter logic [3:0]            ROT_INIT = 4'd1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DW-1:0]         in_data,
  input  logic                  in_mode,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DW-1:0]         out_data,
  input  logic                  out_ready,
  input  logic                  cfg_we,
  input  logic [NKEYS*DW-1:0]   cfg_key,
  input  logic [3:0]            cfg_rot,
  output logic                  cfg_err,
  output logic                  busy
);

  localparam int IW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NKEYS - 1);

  // Stage 1: captured beat together with the key word it must use.
  logic                s1_valid;
  logic [DW-1:0]       s1_data;
  logic                s1_mode;
  logic [DW-1:0]       s1_key;

  // Key schedule state.
  logic [NKEYS*DW-1:0] key_bank;
  logic [3:0]          period;
  logic [3:0]          cnt;
  logic [IW-1:0]       idx;

  logic                advance;
  logic                accept;
  logic [DW-1:0]       cur_key;
  logic [DW-1:0]       result;

  // A shift by DW yields zero, so PROT = 0 degenerates to the identity.
  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] x);
    return (x << PROT) | (x >> (DW - PROT));
  endfunction

  function automatic logic [DW-1:0] rotr(input logic [DW-1:0] x);
    return (x >> PROT) | (x << (DW - PROT));
  endfunction

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign busy     = s1_valid || out_valid;
  assign cur_key  = key_bank[int'(idx)*DW +: DW];
  assign result   = s1_mode ? rotr(s1_data ^ s1_key) : (rotl(s1_data) ^ s1_key);

  // Datapath. Both stages move together on advance. When the pipeline is
  // stalled, every register keeps its value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_mode   <= 1'b0;
      s1_key    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      out_data  <= result;
      s1_valid  <= accept;
      if (accept) begin
        s1_data <= in_data;
        s1_mode <= in_mode;
        s1_key  <= cur_key;
      end
    end
  end

  // Key schedule and configuration. The beat accepted this cycle has
  // already latched cur_key. Any index step therefore takes effect on the
  // following beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_bank <= KEY_INIT;
      period   <= ROT_INIT;
      cnt      <= '0;
      idx      <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (busy || accept);
      if (cfg_we && !busy && !accept) begin
        key_bank <= cfg_key;
        period   <= cfg_rot;
        cnt      <= '0;
        idx      <= '0;
      end else if (accept && (period != 4'd0)) begin
        if (4'(cnt + 4'd1) == period) begin
          cnt <= '0;
          idx <= (idx == LAST_IDX) ? '0 : IW'(idx + IW'(1));
        end else begin
          cnt <= 4'(cnt + 4'd1);
        end
      end
    end
  end

endmodule

// File: tb/tb_xor_cipher_core.sv
module tb_xor_cipher_core;
  localparam int DW    = 8;
  localparam int NKEYS = 3;
  localparam int PROT  = 1;
  localparam logic [23:0] KEY_DEF = 24'h0FA53C;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = '0;
  logic        in_mode  = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic        cfg_we = 1'b0;
  logic [23:0] cfg_key = '0;
  logic [3:0]  cfg_rot = '0;
  logic        cfg_err;
  logic        busy;

  xor_cipher_core #(
    .DW(DW), .NKEYS(NKEYS), .PROT(PROT),
    .KEY_INIT(KEY_DEF), .ROT_INIT(4'd1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_mode(in_mode), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .cfg_we(cfg_we), .cfg_key(cfg_key), .cfg_rot(cfg_rot), .cfg_err(cfg_err),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [DW-1:0] exp_q[$];
  int            lat_q[$];

  // reference model: key word chosen from the number of beats since the
  // last reset/config load
  logic [7:0] m_keys [NKEYS];
  int         m_period;
  int         m_n;

  int ready_mode = 0;  // 0 always ready, 1 random, 2 fixed pattern
  int pat_i = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_load(input logic [23:0] k, input int r);
    for (int i = 0; i < NKEYS; i++) m_keys[i] = k[i*8 +: 8];
    m_period = r;
    m_n = 0;
  endfunction

  function automatic logic [7:0] model_out(input logic [7:0] d, input logic m);
    int k;
    int v;
    int x;
    k = (m_period == 0) ? 0 : ((m_n / m_period) % NKEYS);
    v = int'(d);
    if (!m) begin
      x = (((v << PROT) | (v >> (DW - PROT))) & 255) ^ int'(m_keys[k]);
    end else begin
      x = v ^ int'(m_keys[k]);
      x = ((x >> PROT) | (x << (DW - PROT))) & 255;
    end
    return x[7:0];
  endfunction

  // sink ready driver, changes well after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          out_ready = pat[pat_i % 6];
          pat_i++;
        end
      endcase
    end
  end

  // monitor
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
        if (prev_stall) begin
          chk("hold_valid", 32'(out_valid), 32'd1);
          chk("hold_data", 32'(out_data), 32'(prev_data));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            logic [7:0] e;
            int         a;
            e = exp_q.pop_front();
            a = lat_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e));
            if (ready_mode == 0) chk("latency", 32'(cyc - a), 32'd2);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [7:0] d, input logic m);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(model_out(d, m));
      lat_q.push_back(cyc);
      m_n++;
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || exp_q.size() != 0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("drain_idle", {30'd0, busy, exp_q.size() != 0}, 32'd0);
  endtask

  task automatic cfg(input logic [23:0] k, input logic [3:0] r, input bit with_beat,
                     input logic [7:0] d, input bit exp_err);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_key = k;
    cfg_rot = r;
    if (with_beat) begin
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = 1'b0;
      exp_q.push_back(model_out(d, 1'b0));
      lat_q.push_back(cyc);
      m_n++;
    end
    @(negedge clk);
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'(exp_err));
    if (!exp_err) model_load(k, int'(r));
    @(negedge clk);
    chk("cfg_err_clear", 32'(cfg_err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_load(KEY_DEF, 1);
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // period 0: encrypt then decrypt round trip
    cfg(KEY_DEF, 4'd0, 1'b0, 8'h00, 1'b0);
    send(8'h81, 1'b0);
    wait_idle();
    send(8'h3F, 1'b1);
    wait_idle();

    // period 1 and period 2, back-to-back beats
    cfg(KEY_DEF, 4'd1, 1'b0, 8'h00, 1'b0);
    repeat (4) send(8'h00, 1'b0);
    wait_idle();
    cfg(KEY_DEF, 4'd2, 1'b0, 8'h00, 1'b0);
    repeat (4) send(8'h00, 1'b0);
    wait_idle();

    // stalled stream with a fixed ready pattern
    ready_mode = 2;
    cfg(KEY_DEF, 4'd1, 1'b0, 8'h00, 1'b0);
    repeat (6) send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    wait_idle();
    ready_mode = 0;

    // config refused while busy, accepted while idle
    cfg(KEY_DEF, 4'd3, 1'b0, 8'h00, 1'b0);
    send(8'h00, 1'b0);
    chk("busy_inflight", 32'(busy), 32'd1);
    cfg(24'h000001, 4'd0, 1'b0, 8'h00, 1'b1);
    wait_idle();
    send(8'h00, 1'b0);
    wait_idle();
    cfg(24'h000001, 4'd0, 1'b0, 8'h00, 1'b0);
    send(8'h00, 1'b0);
    wait_idle();
    // config colliding with an accepted beat
    cfg(24'h123456, 4'd5, 1'b1, 8'h5A, 1'b1);
    wait_idle();

    // reset with two beats in flight
    cfg(KEY_DEF, 4'd2, 1'b0, 8'h00, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cfg_err", 32'(cfg_err), 32'd0);
    exp_q.delete();
    lat_q.delete();
    model_load(KEY_DEF, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send(8'h00, 1'b0);
    wait_idle();

    // randomized traffic with random sink stalls
    for (int r = 0; r < 4; r++) begin
      ready_mode = 0;
      cfg(24'($urandom), 4'($urandom_range(0, 15)), 1'b0, 8'h00, 1'b0);
      ready_mode = 1;
      repeat (15) send(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait_idle();
    end
    ready_mode = 0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
